// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the block-RAM FIFO controller in the sdc_read path.
package bram_fifo_pkg;

   localparam int ADDR_W       = 10;
   localparam int DATA_W       = 36;
   localparam int DEPTH        = 2 ** ADDR_W;
   localparam int AFULL_THRESH = 896;
   localparam int BLOCK_WORDS  = 128;

   function automatic int count_w(input int aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/bram_fifo_out_buf.sv
// Two-entry show-ahead buffer that hides the block RAM's one-cycle read latency.
module bram_fifo_out_buf #(
   parameter int DATA_W = bram_fifo_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] data,
   input  logic              pop,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [1:0]        level
);

   logic [DATA_W-1:0] slot0_p2;
   logic [DATA_W-1:0] slot1_p2;
   logic [1:0]        level_q;
   logic              pop_eff;

   assign pop_eff  = pop && (level_q != 2'd0);
   assign rd_valid = (level_q != 2'd0);
   assign rd_data  = rd_valid ? slot0_p2 : '0;
   assign level    = level_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= 2'd0;
      end else if (clear) begin
         level_q <= 2'd0;
      end else begin
         level_q <= level_q + 2'(push) - 2'(pop_eff);
      end
   end

   // Stage p2: slot0 is always the head, so a pop shifts slot1 forward.
   always_ff @(posedge clk) begin
      if (push) begin
         if (pop_eff) begin
            if (level_q == 2'd2) begin
               slot0_p2 <= slot1_p2;
               slot1_p2 <= data;
            end else begin
               slot0_p2 <= data;
            end
         end else if (level_q == 2'd0) begin
            slot0_p2 <= data;
         end else begin
            slot1_p2 <= data;
         end
      end else if (pop_eff) begin
         slot0_p2 <= slot1_p2;
      end
   end

endmodule

// File: rtl/bram_dpm_fifo_ctrl.sv
// Circular FIFO controller over a 1024x36 dual-port block RAM: port A writes, port B reads.
module bram_dpm_fifo_ctrl #(
   parameter int ADDR_W       = bram_fifo_pkg::ADDR_W,
   parameter int DATA_W       = bram_fifo_pkg::DATA_W,
   parameter int AFULL_THRESH = bram_fifo_pkg::AFULL_THRESH,
   parameter int BLOCK_WORDS  = bram_fifo_pkg::BLOCK_WORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] bram_addr_a,
   output logic [DATA_W-1:0] bram_datain_a,
   output logic              bram_wr_a,
   output logic [ADDR_W-1:0] bram_addr_b,
   output logic              bram_wr_b,
   output logic [DATA_W-1:0] bram_datain_b,
   input  logic [DATA_W-1:0] bram_dataout_b,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              block_ready
);

   import bram_fifo_pkg::*;

   localparam int CNT_W = count_w(ADDR_W);
   localparam int DEPTH_W = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH_W + 2);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  mem_count;
   logic              vld_p1;
   logic [1:0]        level;
   logic              wr_acc;
   logic              pop;
   logic              issue;
   logic [2:0]        occ_after_pop;

   function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] c,
                                                   input logic inc, input logic dec);
      if (inc && !dec) return (c == CNT_MAX) ? c : c + CNT_W'(1);
      if (dec && !inc) return (c == '0) ? c : c - CNT_W'(1);
      return c;
   endfunction

   assign full          = (mem_count == CNT_W'(DEPTH_W));
   assign wr_ready      = !full && !flush;
   assign wr_acc        = wr_valid && wr_ready;
   assign pop           = rd_valid && rd_ready;

   // A buffer slot freed by this cycle's pop may be refilled by this cycle's issue.
   assign occ_after_pop = 3'(level) + 3'(vld_p1) - 3'(pop);
   assign issue         = !flush && (mem_count != '0) && (occ_after_pop < 3'd2);

   assign bram_addr_a   = wr_ptr;
   assign bram_datain_a = wr_data;
   assign bram_wr_a     = wr_acc;
   assign bram_addr_b   = rd_ptr;
   assign bram_wr_b     = 1'b0;
   assign bram_datain_b = '0;

   assign empty         = (count == '0);
   assign almost_full   = (count >= CNT_W'(AFULL_THRESH));
   assign block_ready   = (count >= CNT_W'(BLOCK_WORDS));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         vld_p1    <= 1'b0;
         count     <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         vld_p1    <= 1'b0;
         count     <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (issue)  rd_ptr <= rd_ptr + ADDR_W'(1);
         if (wr_acc && !issue)      mem_count <= mem_count + CNT_W'(1);
         else if (issue && !wr_acc) mem_count <= mem_count - CNT_W'(1);
         vld_p1 <= issue;
         count  <= count_next(count, wr_acc, pop);
      end
   end

   // Stage p1: RAM port B data returns and lands at the output buffer tail.
   bram_fifo_out_buf #(
      .DATA_W (DATA_W)
   ) u_out_buf (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .push     (vld_p1),
      .data     (bram_dataout_b),
      .pop      (pop),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .level    (level)
   );

endmodule

// File: tb/tb_bram_dpm_fifo_ctrl.sv
// Self-checking bench for bram_dpm_fifo_ctrl with a behavioural RAM and queue-based FIFO model.
module tb_bram_dpm_fifo_ctrl;

   localparam int AW  = 10;
   localparam int DW  = 36;
   localparam int CAP = 1026;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          wr_valid = 1'b0;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready, rd_valid, bram_wr_a, bram_wr_b;
   logic [DW-1:0] rd_data, bram_datain_a, bram_datain_b;
   logic [DW-1:0] bram_dataout_b;
   logic [AW-1:0] bram_addr_a, bram_addr_b;
   logic [AW:0]   count;
   logic          empty, full, almost_full, block_ready;

   bram_dpm_fifo_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_data        (wr_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_data        (rd_data),
      .bram_addr_a    (bram_addr_a),
      .bram_datain_a  (bram_datain_a),
      .bram_wr_a      (bram_wr_a),
      .bram_addr_b    (bram_addr_b),
      .bram_wr_b      (bram_wr_b),
      .bram_datain_b  (bram_datain_b),
      .bram_dataout_b (bram_dataout_b),
      .count          (count),
      .empty          (empty),
      .full           (full),
      .almost_full    (almost_full),
      .block_ready    (block_ready)
   );

   always #5 clk = ~clk;

   // Behavioural dual-port RAM: synchronous write on A, registered read on B.
   logic [DW-1:0] ram [0:1023];
   always @(posedge clk) begin
      if (bram_wr_a) ram[bram_addr_a] <= bram_datain_a;
      bram_dataout_b <= ram[bram_addr_b];
   end

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] model_q[$];
   int            m_wptr = 0;
   logic          obs_acc, obs_pop;

   task automatic fail_msg(input string name, input logic [63:0] act, input logic [63:0] req);
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   // One clock: drive at negedge, sample 1 ns later, score against the queue model.
   task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
      int sz;
      @(negedge clk);
      wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
      #1;
      sz = model_q.size();
      obs_acc = wr_valid & wr_ready;
      obs_pop = rd_valid & rd_ready;
      checks++; if (count !== 11'(sz)) fail_msg("count", 64'(count), 64'(sz));
      checks++; if (empty !== (sz == 0)) fail_msg("empty", 64'(empty), 64'(sz == 0));
      checks++; if (almost_full !== (sz >= 896)) fail_msg("almost_full", 64'(almost_full), 64'(sz >= 896));
      checks++; if (block_ready !== (sz >= 128)) fail_msg("block_ready", 64'(block_ready), 64'(sz >= 128));
      checks++; if (bram_wr_a !== (wv & wr_ready)) fail_msg("bram_wr_a", 64'(bram_wr_a), 64'(wv & wr_ready));
      checks++; if (bram_addr_a !== 10'(m_wptr)) fail_msg("bram_addr_a", 64'(bram_addr_a), 64'(m_wptr));
      if (fl || sz <= 1023) begin
         checks++; if (wr_ready !== !fl) fail_msg("wr_ready", 64'(wr_ready), 64'(!fl));
      end else if (sz >= CAP) begin
         checks++; if (wr_ready !== 1'b0) fail_msg("wr_ready_cap", 64'(wr_ready), 64'(0));
      end
      if (rd_valid === 1'b1) begin
         checks++;
         if (sz == 0) fail_msg("rd_valid_empty", 64'(1), 64'(0));
         else if (rd_data !== model_q[0]) fail_msg("rd_data_order", 64'(rd_data), 64'(model_q[0]));
      end
      if (obs_pop && sz > 0) void'(model_q.pop_front());
      if (obs_acc) begin
         model_q.push_back(wd);
         m_wptr = (m_wptr + 1) % 1024;
      end
      if (fl) begin
         model_q.delete();
         m_wptr = 0;
      end
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && model_q.size() > 0; i++) cycle(1'b0, '0, 1'($urandom_range(0, 4) != 0), 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      checks++; if (model_q.size() != 0) fail_msg("drain_timeout", 64'(model_q.size()), 64'(0));
      checks++; if (empty !== 1'b1) fail_msg("drain_empty", 64'(empty), 64'(1));
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      checks++; if (count !== '0) fail_msg("rst_count", 64'(count), 64'(0));
      checks++; if (empty !== 1'b1) fail_msg("rst_empty", 64'(empty), 64'(1));
      checks++; if (rd_valid !== 1'b0) fail_msg("rst_rd_valid", 64'(rd_valid), 64'(0));
      checks++; if (rd_data !== '0) fail_msg("rst_rd_data", 64'(rd_data), 64'(0));
      checks++; if (wr_ready !== 1'b1) fail_msg("rst_wr_ready", 64'(wr_ready), 64'(1));
      checks++; if (full !== 1'b0) fail_msg("rst_full", 64'(full), 64'(0));
      checks++; if (bram_wr_b !== 1'b0 || bram_datain_b !== '0) fail_msg("rst_port_b_wr", 64'(bram_wr_b), 64'(0));
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 37; i++) cycle(1'b1, {4'($urandom), 32'($urandom)}, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      checks++; if (count !== 11'd37) fail_msg("pre_reset_count", 64'(count), 64'(37));
      @(negedge clk);
      reset = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
      #1;
      checks++; if (count !== '0) fail_msg("midrst_count", 64'(count), 64'(0));
      checks++; if (empty !== 1'b1) fail_msg("midrst_empty", 64'(empty), 64'(1));
      checks++; if (rd_valid !== 1'b0) fail_msg("midrst_rd_valid", 64'(rd_valid), 64'(0));
      checks++; if (wr_ready !== 1'b1) fail_msg("midrst_wr_ready", 64'(wr_ready), 64'(1));
      checks++; if (bram_wr_a !== 1'b0) fail_msg("midrst_bram_wr_a", 64'(bram_wr_a), 64'(0));
      model_q.delete();
      m_wptr = 0;
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic test_single_word();
      cycle(1'b1, 36'h9_ABCD_1234, 1'b0, 1'b0);
      checks++; if (bram_wr_a !== 1'b1) fail_msg("single_wr_a", 64'(bram_wr_a), 64'(1));
      checks++; if (bram_addr_a !== 10'd0) fail_msg("single_addr_a", 64'(bram_addr_a), 64'(0));
      cycle(1'b0, '0, 1'b0, 1'b0);
      checks++; if (rd_valid !== 1'b0) fail_msg("single_lat1", 64'(rd_valid), 64'(0));
      cycle(1'b0, '0, 1'b0, 1'b0);
      checks++; if (rd_valid !== 1'b0) fail_msg("single_lat2", 64'(rd_valid), 64'(0));
      cycle(1'b0, '0, 1'b0, 1'b0);
      checks++; if (rd_valid !== 1'b1) fail_msg("single_valid", 64'(rd_valid), 64'(1));
      checks++; if (rd_data !== 36'h9_ABCD_1234) fail_msg("single_data", 64'(rd_data), 64'h9_ABCD_1234);
      checks++; if (count !== 11'd1) fail_msg("single_count", 64'(count), 64'(1));
      drain(20);
   endtask

   task automatic test_fill();
      int acc_n = 0;
      int first_af = -1;
      int first_br = -1;
      for (int i = 0; i < 1040; i++) begin
         cycle(1'b1, 36'(acc_n), 1'b0, 1'b0);
         if (almost_full === 1'b1 && first_af < 0) first_af = int'(count);
         if (block_ready === 1'b1 && first_br < 0) first_br = int'(count);
         if (obs_acc) acc_n++;
      end
      checks++; if (acc_n != CAP) fail_msg("fill_accepts", 64'(acc_n), 64'(CAP));
      checks++; if (first_af != 896) fail_msg("fill_afull_at", 64'(first_af), 64'(896));
      checks++; if (first_br != 128) fail_msg("fill_block_at", 64'(first_br), 64'(128));
      checks++; if (full !== 1'b1) fail_msg("fill_full", 64'(full), 64'(1));
      checks++; if (wr_ready !== 1'b0) fail_msg("fill_wr_ready", 64'(wr_ready), 64'(0));
      drain(3000);
   endtask

   task automatic test_full_pushpop();
      for (int i = 0; i < 1040; i++) cycle(1'b1, {4'hA, 32'(i)}, 1'b0, 1'b0);
      checks++; if (count !== 11'(CAP)) fail_msg("pp_count_full", 64'(count), 64'(CAP));
      cycle(1'b1, 36'h0_DEAD_0001, 1'b1, 1'b0);
      checks++; if (wr_ready !== 1'b0) fail_msg("pp_wr_blocked", 64'(wr_ready), 64'(0));
      checks++; if (obs_pop !== 1'b1) fail_msg("pp_pop", 64'(obs_pop), 64'(1));
      cycle(1'b1, 36'h0_DEAD_0002, 1'b1, 1'b0);
      checks++; if (obs_acc !== 1'b1) fail_msg("pp_wr_accept", 64'(obs_acc), 64'(1));
      cycle(1'b0, '0, 1'b0, 1'b0);
      checks++; if (count !== 11'(CAP - 1)) fail_msg("pp_count_after", 64'(count), 64'(CAP - 1));
      drain(4000);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 10; i++) cycle(1'b1, {4'h3, 32'(i)}, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, 36'h0_BAD0_BAD0, 1'b0, 1'b1);
      checks++; if (wr_ready !== 1'b0) fail_msg("flush_wr_ready", 64'(wr_ready), 64'(0));
      cycle(1'b0, '0, 1'b0, 1'b0);
      checks++; if (count !== '0) fail_msg("flush_count", 64'(count), 64'(0));
      checks++; if (rd_valid !== 1'b0) fail_msg("flush_rd_valid", 64'(rd_valid), 64'(0));
      cycle(1'b1, 36'h5_A5A5_A5A5, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 36'h5_A5A5_A5A5) fail_msg("flush_next_word", 64'(rd_data), 64'h5_A5A5_A5A5);
      drain(20);
   endtask

   task automatic test_stream_wrap();
      int accepted = 0;
      int max_cnt = 0;
      for (int i = 0; i < 12000 && accepted < 3000; i++) begin
         cycle(1'($urandom_range(0, 9) < 8), {4'($urandom), 32'($urandom)}, 1'($urandom_range(0, 3) != 0), 1'b0);
         if (int'(count) > max_cnt) max_cnt = int'(count);
         if (obs_acc) accepted++;
      end
      checks++; if (accepted != 3000) fail_msg("stream_accepts", 64'(accepted), 64'(3000));
      checks++; if (max_cnt > CAP) fail_msg("stream_max_count", 64'(max_cnt), 64'(CAP));
      for (int i = 0; i < 200; i++) cycle(1'b1, {4'h7, 32'(i)}, 1'b1, 1'b0);
      drain(4000);
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_fill();
      test_full_pushpop();
      test_flush();
      test_stream_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
